param_updown_counter: RTL

Parametrised successor to the team's 4-bit synchronous loadable up counter. Adds configurable width, up/down direction, a runtime limit (modulus), wrap or saturate mode, count enable, a terminal-count pulse and a sticky overflow flag. Used as a general timer/event counter in datapath control blocks.

---
 rtl/counter_pkg.sv | 55 +++++
 rtl/param_updown_counter.sv | 79 +++++++
 2 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family.
// Contents:
//   MODE_WRAP / MODE_SAT : values of the sat_mode input
//   DIR_DOWN / DIR_UP    : values of the up input
//   step_t, next_step()  : one enabled counting step, including clamping and
//                          boundary detection. Works on 32-bit operands so that
//                          any counter width up to 32 can reuse it.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  localparam int unsigned MAX_WIDTH = 32;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] count;
    logic                 boundary;  // step hit limit (up) or zero (down)
  } step_t;

  // Result of one enabled step. Operands are zero-extended by the caller.
  // A count above limit (limit lowered at runtime) is pulled back to limit,
  // and that is not a boundary event.
  function automatic step_t next_step(
    input logic [MAX_WIDTH-1:0] count,
    input logic [MAX_WIDTH-1:0] limit,
    input logic                 up,
    input logic                 sat_mode
  );
    step_t r;
    r.count    = count;
    r.boundary = 1'b0;
    if (count > limit) begin
      r.count = limit;
    end else if (up == DIR_UP) begin
      if (count == limit) begin
        r.boundary = 1'b1;
        r.count    = (sat_mode == MODE_SAT) ? limit : '0;
      end else begin
        // count < limit, so the sum never exceeds limit or the counter width.
        r.count = count + 1'b1;
      end
    end else begin
      if (count == '0) begin
        r.boundary = 1'b1;
        r.count    = (sat_mode == MODE_SAT) ? '0 : limit;
      end else begin
        r.count = count - 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/param_updown_counter.sv
// Parametrised loadable up/down counter with runtime limit, wrap/saturate
// mode, terminal-count pulse and sticky overflow flag.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   load, d  : synchronous load (value clamped to limit), wins over en
//   en, up   : count enable and direction (1 = up)
//   sat_mode : 0 = wrap at boundary, 1 = saturate at boundary
//   limit    : inclusive maximum count
//   clr_ovf  : synchronous clear of ovf (a same-edge boundary event wins)
//   count    : registered count
//   tc       : registered one-cycle pulse per boundary event
//   ovf      : sticky boundary flag
//   at_max   : count == limit (combinational)
//   at_zero  : count == 0 (combinational)
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_zero
);

  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;
  step_t            step;

  assign step = next_step(MAX_WIDTH'(count), MAX_WIDTH'(limit), up, sat_mode);

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    ovf_nxt   = ovf & ~clr_ovf;
    if (load) begin
      count_nxt = (d > limit) ? limit : d;
    end else if (en) begin
      count_nxt = step.count[WIDTH-1:0];
      tc_nxt    = step.boundary;
      if (step.boundary) begin
        ovf_nxt = 1'b1;  // set wins over a simultaneous clear
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= WIDTH'(RST_VAL);
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign at_max  = (count == limit);
  assign at_zero = (count == '0);

endmodule
